// File: rtl/usb_pkg.sv
// usb_pkg: shared PID codes, CRC5 constants/helpers and token-TX FSM states.
package usb_pkg;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    localparam logic [4:0] CRC5_POLY     = 5'b00101;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_B1, ST_B2, ST_GAP} state_t;

    function automatic logic is_token(input logic [3:0] pid);
        return pid == PID_OUT || pid == PID_IN || pid == PID_SOF ||
               pid == PID_SETUP || pid == PID_PING;
    endfunction

    // Serial CRC5 remainder, d[0] is the first bit on the wire.
    function automatic logic [4:0] crc5_rem(input logic [10:0] d);
        logic [4:0] crc;
        crc = CRC5_INIT;
        for (int i = 0; i < 11; i++)
            crc = {crc[3:0], 1'b0} ^ ((d[i] ^ crc[4]) ? CRC5_POLY : 5'b0);
        return crc;
    endfunction
endpackage

// File: rtl/crc5_t_crc5_gen.sv
// crc5_gen: combinational CRC5 over an 11-bit token field, inverted output.
//   i_data  11-bit field, bit 0 first on the wire
//   o_crc   inverted remainder; o_crc[4] is the first CRC bit on the wire
module crc5_gen
    import usb_pkg::*;
(
    input  logic [10:0] i_data,
    output logic [4:0]  o_crc
);
    assign o_crc = ~crc5_rem(i_data);
endmodule

// File: rtl/crc5_t.sv
// crc5_t: token packet transmitter (PID, field byte, field+CRC5 byte) over a byte stream.
//   i_crc5_t_clk/rst           clock, synchronous active-high reset
//   i_crc5_t_req/pid/addr/endp/frame, o_crc5_t_req_ready/req_err   request side
//   o_crc5_t_tx_lp_data/sop/eop/valid, i_crc5_t_tx_lp_ready          link-layer side
//   o_crc5_t_done              pulse after the eop beat is accepted
module crc5_t
    import usb_pkg::*;
#(
    parameter int IFG_CYCLES = 2,
    parameter bit CHK_PID    = 1'b1
) (
    input  logic        i_crc5_t_clk,
    input  logic        i_crc5_t_rst,
    input  logic        i_crc5_t_req,
    input  logic [3:0]  i_crc5_t_pid,
    input  logic [6:0]  i_crc5_t_addr,
    input  logic [3:0]  i_crc5_t_endp,
    input  logic [10:0] i_crc5_t_frame,
    input  logic        i_crc5_t_tx_lp_ready,
    output logic        o_crc5_t_req_ready,
    output logic        o_crc5_t_req_err,
    output logic        o_crc5_t_done,
    output logic [7:0]  o_crc5_t_tx_lp_data,
    output logic        o_crc5_t_tx_lp_sop,
    output logic        o_crc5_t_tx_lp_eop,
    output logic        o_crc5_t_tx_lp_valid
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] fld_q, fld_d;
    logic [7:0]  data_q, data_d;
    logic        sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
    logic        req_ready_q, req_ready_d, req_err_q, req_err_d, done_q, done_d;
    logic [4:0]  crc;
    logic        fire;

    // Token and SOF share one layout: byte1 = fld[7:0], byte2 tail = fld[10:8].
    crc5_gen u_crc (.i_data(fld_q), .o_crc(crc));

    assign fire = valid_q & i_crc5_t_tx_lp_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fld_d     = fld_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        valid_d   = valid_q;
        req_err_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (i_crc5_t_req) begin
                fld_d = i_crc5_t_pid == PID_SOF ? i_crc5_t_frame : {i_crc5_t_endp, i_crc5_t_addr};
                if (CHK_PID && !is_token(i_crc5_t_pid)) begin
                    req_err_d = 1'b1;
                end else begin
                    state_d = ST_PID;
                    data_d  = {~i_crc5_t_pid, i_crc5_t_pid};
                    sop_d   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            ST_PID: if (fire) begin
                state_d = ST_B1;
                data_d  = fld_q[7:0];
                sop_d   = 1'b0;
            end
            ST_B1: if (fire) begin
                state_d = ST_B2;
                data_d  = {crc[0], crc[1], crc[2], crc[3], crc[4], fld_q[10:8]};
                eop_d   = 1'b1;
            end
            ST_B2: if (fire) begin
                state_d = IFG_CYCLES == 0 ? ST_IDLE : ST_GAP;
                cnt_d   = '0;
                data_d  = '0;
                eop_d   = 1'b0;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            ST_GAP: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == 4'(IFG_CYCLES - 1) ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = state_d == ST_IDLE;
    end

    always_ff @(posedge i_crc5_t_clk) begin
        if (i_crc5_t_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fld_q       <= '0;
            data_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            valid_q     <= 1'b0;
            req_ready_q <= 1'b1;
            req_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fld_q       <= fld_d;
            data_q      <= data_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            valid_q     <= valid_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            done_q      <= done_d;
        end
    end

    assign o_crc5_t_req_ready   = req_ready_q;
    assign o_crc5_t_req_err     = req_err_q;
    assign o_crc5_t_done        = done_q;
    assign o_crc5_t_tx_lp_data  = data_q;
    assign o_crc5_t_tx_lp_sop   = sop_q;
    assign o_crc5_t_tx_lp_eop   = eop_q;
    assign o_crc5_t_tx_lp_valid = valid_q;
endmodule

// File: tb/tb_crc5_t.sv
// tb_crc5_t: directed checks of the token transmitter with hand-computed beats.
module tb_crc5_t;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, tx_ready = 1'b1;
    logic [3:0]  pid = '0, endp = '0;
    logic [6:0]  addr = '0;
    logic [10:0] frame = '0;
    logic        req_ready, req_err, done, sop, eop, valid;
    logic [7:0]  data;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    crc5_t dut (
        .i_crc5_t_clk(clk), .i_crc5_t_rst(rst), .i_crc5_t_req(req),
        .i_crc5_t_pid(pid), .i_crc5_t_addr(addr), .i_crc5_t_endp(endp),
        .i_crc5_t_frame(frame), .i_crc5_t_tx_lp_ready(tx_ready),
        .o_crc5_t_req_ready(req_ready), .o_crc5_t_req_err(req_err), .o_crc5_t_done(done),
        .o_crc5_t_tx_lp_data(data), .o_crc5_t_tx_lp_sop(sop),
        .o_crc5_t_tx_lp_eop(eop), .o_crc5_t_tx_lp_valid(valid)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {valid, sop, eop, data}
    task automatic beat(input string tag, input logic v, input logic s, input logic e, input logic [7:0] d);
        chk(tag, {5'b0, valid, sop, eop, data}, {5'b0, v, s, e, d});
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 20 && !req_ready; i++) step;
        chk("ready_timeout", req_ready, 1'b1);
    endtask

    // Remainder over the 16 bits after the PID, byte1 bit 0 first on the wire.
    function automatic logic [4:0] residual(input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] s;
        logic [4:0] crc;
        s = {b2, b1};
        crc = 5'b11111;
        for (int i = 0; i < 16; i++)
            crc = {crc[3:0], 1'b0} ^ ((s[i] ^ crc[4]) ? 5'b00101 : 5'b0);
        return crc;
    endfunction

    initial begin
        logic [3:0] toks [5];
        logic       pat [6];
        logic [7:0] sof_b [3];
        logic [7:0] b1, b2, exp_b1;
        int         b, cyc, first_sop, second_sop, nsop;
        toks  = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h4};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        sof_b = '{8'hA5, 8'hFF, 8'h47};

        step; step;
        beat("rst_beat", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_flags", {req_ready, req_err, done}, 3'b100);
        rst = 1'b0;

        // SETUP addr 0 endp 0 -> 2D 00 10
        req = 1'b1; pid = 4'hD; addr = 7'h00; endp = 4'h0;
        step;
        req = 1'b0; addr = 7'h7F; endp = 4'hF;
        beat("setup_pid", 1'b1, 1'b1, 1'b0, 8'h2D);
        chk("setup_busy", req_ready, 1'b0);
        step; beat("setup_b1", 1'b1, 1'b0, 1'b0, 8'h00);
        step; beat("setup_b2", 1'b1, 1'b0, 1'b1, 8'h10);
        step; chk("setup_done", {valid, done, req_ready}, 3'b010);
        step; chk("setup_gap2", {done, req_ready}, 2'b00);
        step; chk("setup_idle", req_ready, 1'b1);

        // SOF frame 7FF with ready stalls -> A5 FF 47
        req = 1'b1; pid = 4'h5; frame = 11'h7FF;
        step;
        req = 1'b0; frame = 11'h000;
        b = 0;
        for (int k = 0; k < 6; k++) begin
            beat($sformatf("sof_beat%0d", k), 1'b1, b == 0, b == 2, sof_b[b]);
            tx_ready = pat[k];
            step;
            if (pat[k]) b++;
        end
        tx_ready = 1'b1;
        chk("sof_done", {valid, done}, 2'b01);
        step; chk("sof_done_once", done, 1'b0);
        wait_ready;

        // DATA0 rejected
        req = 1'b1; pid = 4'h3;
        step;
        req = 1'b0;
        chk("data0_err", {req_err, valid, req_ready}, 3'b101);
        step; chk("data0_after", {req_err, valid, req_ready}, 3'b001);

        // reset during B1, then a clean OUT packet
        req = 1'b1; pid = 4'h1; addr = 7'h05; endp = 4'h3;
        step; req = 1'b0;
        step; beat("abort_b1", 1'b1, 1'b0, 1'b0, 8'h85);
        rst = 1'b1;
        step; chk("abort_rst", {valid, eop, done}, 3'b000);
        rst = 1'b0;
        step; chk("abort_idle", {valid, done, req_ready}, 3'b001);
        req = 1'b1; pid = 4'h1; addr = 7'h3A; endp = 4'hA;
        step; req = 1'b0;
        beat("post_pid", 1'b1, 1'b1, 1'b0, 8'hE1);
        step; beat("post_b1", 1'b1, 1'b0, 1'b0, 8'h3A);
        b1 = data;
        step; chk("post_eop", {valid, eop, data[2:0]}, 5'b11101);
        chk("post_res", residual(b1, data), 5'b01100);
        step; chk("post_done", done, 1'b1);
        wait_ready;

        // random tokens: PID byte form, field byte and CRC residual
        for (int n = 0; n < 1000; n++) begin
            req = 1'b1;
            pid = toks[$urandom_range(0, 4)];
            addr = 7'($urandom); endp = 4'($urandom); frame = 11'($urandom);
            exp_b1 = pid == 4'h5 ? frame[7:0] : {endp[0], addr};
            step; req = 1'b0;
            beat("rnd_pid", 1'b1, 1'b1, 1'b0, {~pid, pid});
            step; b1 = data; chk("rnd_b1", b1, exp_b1);
            step; b2 = data; chk("rnd_eop", {valid, sop, eop}, 3'b101);
            chk("rnd_res", residual(b1, b2), 5'b01100);
            step; wait_ready;
        end

        // req held high: sop every 3 beats + 2 gap + 1 accept cycle
        req = 1'b1; pid = 4'h9; addr = 7'h11; endp = 4'h2;
        first_sop = -1; second_sop = -1; nsop = 0;
        for (cyc = 0; cyc < 14; cyc++) begin
            step;
            if (valid && sop) begin
                nsop++;
                if (first_sop < 0) first_sop = cyc;
                else if (second_sop < 0) second_sop = cyc;
            end
        end
        req = 1'b0;
        chk("b2b_count", 16'(nsop), 16'd3);
        chk("b2b_space", 16'(second_sop - first_sop), 16'd6);
        step; step; wait_ready;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
